chunked_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor: the generalised successor of the team's fixed 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock and carries the ripple between chunks in a register, so wide operands reuse a narrow adder slice. Operands arrive and results leave over valid/ready handshakes. It sits between the operand register file and the ALU result mux.

---
 rtl/chunked_addsub.sv | 83 ++++++++
 tb/tb_chunked_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that ripples CHUNK bits per clock,
// carrying between chunks in a register, with valid/ready handshakes on both sides.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum_nxt;
    logic [KW-1:0] k;
    logic [CHUNK-1:0] ca, cb, s;
    logic carry, last, c, c7;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign last = k == KW'(NCHUNK - 1);
    assign ca = opa[k*CHUNK +: CHUNK];
    assign cb = opb[k*CHUNK +: CHUNK];
    assign {c, s} = {1'b0, ca} + {1'b0, cb} + (CHUNK + 1)'(carry);
    // carry into the MSB recovered from the MSB's own sum and operand bits
    assign c7 = s[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    always_comb begin
        sum_nxt = sum;
        sum_nxt[k*CHUNK +: CHUNK] = s;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                // subtraction becomes A + ~B + ~borrow
                opa   <= a;
                opb   <= b ^ {WIDTH{sub}};
                carry <= cin ^ sub;
                k     <= '0;
            end else if (state == RUN) begin
                sum   <= sum_nxt;
                carry <= c;
                if (last) begin
                    cout <= c;
                    ovf  <= c ^ c7;
                    zero <= ~|sum_nxt;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: checks four parameterisations of chunked_addsub against
// spec vectors, hand-written corner sequences and an arithmetic reference model.
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] iv = '0, orr = '0, ci = '0, sb = '0;
    logic [3:0] ir, ov, co, of, zr;
    logic [31:0] a_s [4];
    logic [31:0] b_s [4];
    logic [31:0] sum_s [4];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 4; g++) begin : u
        localparam int W = g == 3 ? 32 : 16;
        localparam int C = g == 0 ? 4 : g == 1 ? 16 : g == 2 ? 1 : 8;
        logic [W-1:0] s;
        chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a_s[g][W-1:0]), .b(b_s[g][W-1:0]), .cin(ci[g]), .sub(sb[g]),
            .out_valid(ov[g]), .out_ready(orr[g]),
            .sum(s), .cout(co[g]), .ovf(of[g]), .zero(zr[g])
        );
        assign sum_s[g] = 32'(s);
    end

    function automatic int wd(int i);
        return i == 3 ? 32 : 16;
    endfunction

    function automatic int nch(int i);
        return i == 0 ? 4 : i == 1 ? 1 : i == 2 ? 16 : 4;
    endfunction

    // plain integer arithmetic: unsigned result, borrow/carry, signed range test
    function automatic void model(input int w, input longint a, input longint b, input bit c,
                                  input bit s, output longint rs, output bit rc,
                                  output bit ro, output bit rz);
        longint m = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint sa = a >= half ? a - (m + 1) : a;
        longint sbv = b >= half ? b - (m + 1) : b;
        longint sr = s ? sa - sbv - longint'(c) : sa + sbv + longint'(c);
        if (s) begin
            rs = (a - b - longint'(c)) & m;
            rc = a >= b + longint'(c);
        end else begin
            rs = (a + b + longint'(c)) & m;
            rc = ((a + b + longint'(c)) >> w) != 0;
        end
        ro = sr < -half || sr >= half;
        rz = rs == 0;
    endfunction

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic issue(input int i, input longint a, input longint b, input bit c, input bit s);
        @(negedge clk);
        chk("in_ready_idle", longint'(ir[i]), 1);
        a_s[i] = 32'(a);
        b_s[i] = 32'(b);
        ci[i] = c;
        sb[i] = s;
        iv[i] = 1'b1;
        @(posedge clk);
        #1 iv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int lat = 0;
        while (!ov[i] && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", lat, nch(i));
    endtask

    task automatic check_res(input int i, input longint a, input longint b, input bit c, input bit s);
        longint rs;
        bit rc, ro, rz;
        model(wd(i), a, b, c, s, rs, rc, ro, rz);
        chk("model_sum", longint'(sum_s[i]), rs);
        chk("model_cout", longint'(co[i]), longint'(rc));
        chk("model_ovf", longint'(of[i]), longint'(ro));
        chk("model_zero", longint'(zr[i]), longint'(rz));
    endtask

    task automatic release_out(input int i);
        @(negedge clk);
        orr[i] = 1'b1;
        @(posedge clk);
        #1 orr[i] = 1'b0;
        chk("out_valid_drop", longint'(ov[i]), 0);
        chk("in_ready_back", longint'(ir[i]), 1);
    endtask

    task automatic op(input int i, input longint a, input longint b, input bit c, input bit s);
        issue(i, a, b, c, s);
        wait_done(i);
        check_res(i, a, b, c, s);
        release_out(i);
    endtask

    typedef struct {
        longint a, b;
        bit c, s;
        longint es;
        bit ec, eo, ez;
    } vec_t;

    initial begin
        vec_t tbl [6];
        tbl = '{
            '{'h1234, 'h1111, 0, 0, 'h2345, 0, 0, 0},
            '{'hFFFF, 'h0001, 0, 0, 'h0000, 1, 0, 1},
            '{'h7FFF, 'h0001, 0, 0, 'h8000, 0, 1, 0},
            '{'h0005, 'h0007, 0, 1, 'hFFFE, 0, 0, 0},
            '{'h0010, 'h0001, 1, 1, 'h000E, 1, 0, 0},
            '{'h8000, 'h0001, 0, 1, 'h7FFF, 1, 1, 0}
        };
        for (int i = 0; i < 4; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        #2;
        chk("rst_in_ready", longint'(ir), 'hF);
        chk("rst_out_valid", longint'(ov), 0);
        chk("rst_sum", longint'(sum_s[0]), 0);
        chk("rst_flags", longint'({co[0], of[0], zr[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            issue(0, tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].s);
            wait_done(0);
            chk("vec_sum", longint'(sum_s[0]), tbl[t].es);
            chk("vec_cout", longint'(co[0]), longint'(tbl[t].ec));
            chk("vec_ovf", longint'(of[0]), longint'(tbl[t].eo));
            chk("vec_zero", longint'(zr[0]), longint'(tbl[t].ez));
            release_out(0);
        end

        // abort mid-RUN with an asynchronous reset
        issue(0, 'h1234, 'h1111, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(ov[0]), 0);
        chk("abort_sum", longint'(sum_s[0]), 0);
        chk("abort_in_ready", longint'(ir[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_abort_out_valid", longint'(ov[0]), 0);
        chk("post_abort_in_ready", longint'(ir[0]), 1);
        issue(0, 'h1234, 'h1111, 0, 0);
        wait_done(0);
        chk("post_abort_sum", longint'(sum_s[0]), 'h2345);
        chk("post_abort_cout", longint'(co[0]), 0);
        release_out(0);

        // backpressure: held result, ignored inputs
        issue(0, 'h1234, 'h4321, 1, 0);
        wait_done(0);
        repeat (5) begin
            @(negedge clk);
            a_s[0] = $urandom;
            b_s[0] = $urandom;
            ci[0] = ~ci[0];
            sb[0] = ~sb[0];
            iv[0] = ~iv[0];
            @(posedge clk);
            #1;
            chk("hold_sum", longint'(sum_s[0]), 'h5556);
            chk("hold_flags", longint'({co[0], of[0], zr[0]}), 0);
            chk("hold_in_ready", longint'(ir[0]), 0);
            chk("hold_out_valid", longint'(ov[0]), 1);
        end
        iv[0] = 1'b0;
        release_out(0);
        op(0, 'hABCD, 'h1357, 0, 1);

        // parameter sweep against the reference model
        for (int i = 1; i < 4; i++) begin
            longint m = (longint'(1) << wd(i)) - 1;
            int n = i == 3 ? 1000 : 40;
            for (int r = 0; r < n; r++) begin
                longint a = longint'($urandom) & m;
                longint b = longint'($urandom) & m;
                if (r % 17 == 0) a = m;
                if (r % 23 == 0) b = longint'(1) << (wd(i) - 1);
                op(i, a, b, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
